pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Drives the write enables of PC, IF_ID, ID_EX, EX_MEM and MEM_WB, plus the IF_ID flush and ID_EX bubble selects.
- Resolves load-use hazards, taken-branch flushes, data-memory wait states and a halt/drain/resume sequence.
- Holds no datapath; one instance sits beside the pipeline registers in the top level.

Parameters:
REG_ADDR_W, 3, register address width
BR_FLUSH_CYCLES, 2, cycles the younger stages are squashed after a taken branch (1..3)
DRAIN_CYCLES, 3, bubble cycles before HALTED so EX/MEM/WB retire
MEM_TIMEOUT, 15, max consecutive dmem_busy cycles before fault

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_rs1_addr  in  REG_ADDR_W  rs1 of instruction in ID
id_rs2_addr  in  REG_ADDR_W  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd_addr  in  REG_ADDR_W  rd held in ID_EX
ex_mem_read  in  1  ID_EX ctrl_MEM_read
branch_taken  in  1  EX resolved a taken branch/jump
dmem_busy  in  1  data memory not ready this cycle
halt_req  in  1  level request to halt
resume_req  in  1  pulse to leave HALTED
pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  register write enables
if_id_flush  out  1  load NOP into IF_ID
id_ex_bubble  out  1  zero ID_EX control inputs (requires id_ex_we=1)
halted  out  1  core halted
mem_timeout  out  1  sticky fault
stall_cycles  out  16  stall statistics (see option)
flush_cycles  out  16  flush statistics (see option)

Behaviour:
- Reset (reset_n=0, immediate): state=RUN, counters=0, mem_timeout=0.
  - All *_we=0; if_id_flush=0; id_ex_bubble=0; halted=0; stats=0.
- All outputs are combinational from state, counters and current inputs. Zero-cycle latency.
- States: RUN, BR_FLUSH, MEM_WAIT, HALT_DRAIN, HALTED. ret_state register records where to resume after MEM_WAIT.
- Priority within a cycle: dmem_busy > branch_taken > load-use > halt_req.
- Global freeze: in any state except HALTED, dmem_busy=1 forces all five *_we=0, flush=0, bubble=0.
  - Entering from another state: ret_state<=current state, wait_cnt<=1, state<=MEM_WAIT.
  - BR_FLUSH and HALT_DRAIN counters do not advance while frozen.
- MEM_WAIT: while busy, wait_cnt increments.
  - If wait_cnt reaches MEM_TIMEOUT while still busy: mem_timeout<=1 (sticky) and state<=HALTED.
  - When busy=0: outputs are those of ret_state that cycle, and state<=ret_state.
- RUN (not busy), default: all *_we=1.
  - branch_taken: pc_we=1 (target), if_id_flush=1, id_ex_bubble=1. If BR_FLUSH_CYCLES>1, state<=BR_FLUSH with flush_cnt<=1.
  - Load-use: ex_mem_read & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
    - Response: pc_we=0, if_id_we=0, id_ex_bubble=1. Exactly one cycle; the bubble clears the condition.
  - halt_req (no branch, no load-use): pc_we=0, if_id_flush=1, id_ex_bubble=1, state<=HALT_DRAIN, drain_cnt<=1.
- BR_FLUSH: pc_we=1, if_id_flush=1, id_ex_bubble=1. flush_cnt++.
  - When flush_cnt==BR_FLUSH_CYCLES-1: state<=RUN.
  - branch_taken here restarts flush_cnt at 1.
- HALT_DRAIN: pc_we=0, if_id_we=0, id_ex_bubble=1, ex_mem_we=1, mem_wb_we=1. After DRAIN_CYCLES: state<=HALTED.
- HALTED: all *_we=0; halted=1.
  - resume_req=1 and mem_timeout=0: state<=RUN next cycle.
  - resume_req is ignored while mem_timeout=1; only reset clears it.
- halt_req is level-sampled only in RUN. It is deferred, not lost, behind branch or load-use.
- Address compare uses full REG_ADDR_W. Register 0 is not special.

Optional Feature:
PIPE_STALL_STATS_EN
- Defined: stall_cycles increments on every cycle with pc_we=0 outside HALTED. flush_cycles increments on every cycle with if_id_flush=1.
  - Both are 16-bit, saturating at 16'hFFFF, and cleared by reset.
- Undefined: no counter flops; both ports are tied to 0.

Decomposition:
- Package pipeline_ctrl_pkg:
  - State enum (3-bit encoding).
  - REG_ADDR_W default.
  - Counter widths (clog2 of MEM_TIMEOUT+1, BR_FLUSH_CYCLES, DRAIN_CYCLES).
- Sub-module load_use_detect: combinational compare that produces the hazard flag. Unit-tested separately.

Test Plan:
- ex_mem_read=1, ex_rd_addr=3, id_rs1_addr=3, id_uses_rs1=1 -> one cycle pc_we=0, if_id_we=0, id_ex_bubble=1. Next cycle all *_we=1.
- branch_taken pulse with BR_FLUSH_CYCLES=2 -> if_id_flush=1 and id_ex_bubble=1 for exactly 2 cycles; pc_we=1 throughout; then RUN.
- dmem_busy held 4 cycles during BR_FLUSH cycle 1 -> all *_we=0 for 4 cycles; then the remaining flush cycle completes; mem_timeout=0.
- dmem_busy held 15 cycles -> mem_timeout=1 and halted=1. resume_req ignored; reset_n low clears both.
- halt_req=1 in RUN -> 3 drain cycles with ex_mem_we=mem_wb_we=1, then halted=1. resume_req pulse -> RUN, all *_we=1.
- reset_n asserted mid-HALT_DRAIN -> all outputs 0 immediately. After release, RUN with *_we=1.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer:
// state encoding, control-bundle patterns and counter sizing helper.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W_DEF      = 3;
    localparam int BR_FLUSH_CYCLES_DEF = 2;
    localparam int DRAIN_CYCLES_DEF    = 3;
    localparam int MEM_TIMEOUT_DEF     = 15;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_BR_FLUSH   = 3'd1,
        ST_MEM_WAIT   = 3'd2,
        ST_HALT_DRAIN = 3'd3,
        ST_HALTED     = 3'd4
    } ctrl_state_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
        logic if_id_flush;
        logic id_ex_bubble;
    } ctrl_out_t;

    // Canonical enable/flush patterns driven onto the pipeline registers
    localparam ctrl_out_t CTRL_FREEZE = 7'b0000000;
    localparam ctrl_out_t CTRL_RUN    = 7'b1111100;
    localparam ctrl_out_t CTRL_FLUSH  = 7'b1111111;
    localparam ctrl_out_t CTRL_HOLD   = 7'b0011101;
    localparam ctrl_out_t CTRL_HALT   = 7'b0111111;

    // Bits needed to hold values 0..max_val, never less than one
    function automatic int cnt_w(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: an ID source operand matches the rd of a load in EX.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mem_read,
    output logic                  hazard
);

    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [1:0]            src_used;
    logic [1:0]            src_match;

    assign src_addr[0] = id_rs1_addr;
    assign src_addr[1] = id_rs2_addr;
    assign src_used    = {id_uses_rs2, id_uses_rs1};

    // Full-width compare; register 0 gets no special treatment
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && (src_addr[gi] == ex_rd_addr);
        end
    endgenerate

    assign hazard = ex_mem_read && (|src_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Optional statistics
// counters are built only when PIPE_STALL_STATS_EN is defined.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W      = REG_ADDR_W_DEF,
    parameter int BR_FLUSH_CYCLES = BR_FLUSH_CYCLES_DEF,
    parameter int DRAIN_CYCLES    = DRAIN_CYCLES_DEF,
    parameter int MEM_TIMEOUT     = MEM_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_mem_read,
    input  logic                  branch_taken,
    input  logic                  dmem_busy,
    input  logic                  halt_req,
    input  logic                  resume_req,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic                  id_ex_we,
    output logic                  ex_mem_we,
    output logic                  mem_wb_we,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  halted,
    output logic                  mem_timeout,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_cycles
);

    localparam int WAIT_W  = cnt_w(MEM_TIMEOUT);
    localparam int WAIT_XW = WAIT_W + 1;
    localparam int FLUSH_W = cnt_w(BR_FLUSH_CYCLES);
    localparam int DRAIN_W = cnt_w(DRAIN_CYCLES);

    localparam logic [WAIT_XW-1:0] WAIT_LIMIT = WAIT_XW'(MEM_TIMEOUT);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(BR_FLUSH_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);

    ctrl_state_e          state_reg, state_next;
    ctrl_state_e          ret_state_reg, ret_state_next;
    ctrl_state_e          eff_state;
    logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [WAIT_XW-1:0]   wait_inc;
    logic [FLUSH_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic [DRAIN_W-1:0]   drain_cnt_reg, drain_cnt_next;
    logic                 timeout_reg, timeout_next;
    logic                 load_use;
    ctrl_out_t            ctrl;
    ctrl_out_t            ctrl_gated;

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use (
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd_addr  (ex_rd_addr),
        .ex_mem_read (ex_mem_read),
        .hazard      (load_use)
    );

    assign wait_inc = {1'b0, wait_cnt_reg} + WAIT_XW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_RUN;
            ret_state_reg <= ST_RUN;
            wait_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
            drain_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ret_state_reg <= ret_state_next;
            wait_cnt_reg  <= wait_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            timeout_reg   <= timeout_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ret_state_next = ret_state_reg;
        wait_cnt_next  = wait_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        timeout_next   = timeout_reg;
        ctrl           = CTRL_FREEZE;
        // The cycle a memory wait resolves behaves exactly like the interrupted state
        eff_state      = (state_reg == ST_MEM_WAIT) ? ret_state_reg : state_reg;

        if (state_reg == ST_HALTED) begin
            if (resume_req && !timeout_reg) begin
                state_next = ST_RUN;
            end
        end else if (dmem_busy) begin
            if (state_reg == ST_MEM_WAIT) begin
                if (wait_inc >= WAIT_LIMIT) begin
                    timeout_next = 1'b1;
                    state_next   = ST_HALTED;
                end else begin
                    wait_cnt_next = wait_inc[WAIT_W-1:0];
                end
            end else begin
                ret_state_next = state_reg;
                wait_cnt_next  = WAIT_W'(1);
                state_next     = ST_MEM_WAIT;
            end
        end else begin
            state_next = eff_state;
            case (eff_state)
                ST_RUN: begin
                    ctrl = CTRL_RUN;
                    if (branch_taken) begin
                        ctrl = CTRL_FLUSH;
                        if (BR_FLUSH_CYCLES > 1) begin
                            state_next     = ST_BR_FLUSH;
                            flush_cnt_next = FLUSH_W'(1);
                        end
                    end else if (load_use) begin
                        ctrl = CTRL_HOLD;
                    end else if (halt_req) begin
                        ctrl           = CTRL_HALT;
                        state_next     = ST_HALT_DRAIN;
                        drain_cnt_next = DRAIN_W'(1);
                    end
                end
                ST_BR_FLUSH: begin
                    ctrl = CTRL_FLUSH;
                    if (branch_taken) begin
                        flush_cnt_next = FLUSH_W'(1);
                    end else if (flush_cnt_reg == FLUSH_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        flush_cnt_next = flush_cnt_reg + FLUSH_W'(1);
                    end
                end
                ST_HALT_DRAIN: begin
                    ctrl = CTRL_HOLD;
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_next = ST_HALTED;
                    end else begin
                        drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
                    end
                end
                default: begin
                    // ret_state never holds MEM_WAIT or HALTED; recover to RUN
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // Outputs fall to zero the moment reset is asserted, before any clock edge
    assign ctrl_gated   = reset_n ? ctrl : CTRL_FREEZE;
    assign pc_we        = ctrl_gated.pc_we;
    assign if_id_we     = ctrl_gated.if_id_we;
    assign id_ex_we     = ctrl_gated.id_ex_we;
    assign ex_mem_we    = ctrl_gated.ex_mem_we;
    assign mem_wb_we    = ctrl_gated.mem_wb_we;
    assign if_id_flush  = ctrl_gated.if_id_flush;
    assign id_ex_bubble = ctrl_gated.id_ex_bubble;
    assign halted       = reset_n && (state_reg == ST_HALTED);
    assign mem_timeout  = timeout_reg;

`ifdef PIPE_STALL_STATS_EN
    logic [15:0] stall_stat_reg;
    logic [15:0] flush_stat_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_stat_reg <= '0;
            flush_stat_reg <= '0;
        end else begin
            if (!ctrl.pc_we && (state_reg != ST_HALTED) && (stall_stat_reg != 16'hFFFF)) begin
                stall_stat_reg <= stall_stat_reg + 16'd1;
            end
            if (ctrl.if_id_flush && (flush_stat_reg != 16'hFFFF)) begin
                flush_stat_reg <= flush_stat_reg + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_stat_reg;
    assign flush_cycles = flush_stat_reg;
`else
    assign stall_cycles = 16'h0000;
    assign flush_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// stimulus against a counter-based behavioural model of the sequencer.
module tb_pipeline_hazard_ctrl;

    localparam int REG_ADDR_W      = 3;
    localparam int BR_FLUSH_CYCLES = 2;
    localparam int DRAIN_CYCLES    = 3;
    localparam int MEM_TIMEOUT     = 15;
`ifdef PIPE_STALL_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [REG_ADDR_W-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic                  id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic                  branch_taken, dmem_busy, halt_req, resume_req;
    logic                  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic                  if_id_flush, id_ex_bubble, halted, mem_timeout;
    logic [15:0]           stall_cycles, flush_cycles;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W      (REG_ADDR_W),
        .BR_FLUSH_CYCLES (BR_FLUSH_CYCLES),
        .DRAIN_CYCLES    (DRAIN_CYCLES),
        .MEM_TIMEOUT     (MEM_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_rs1_addr  (id_rs1_addr),
        .id_rs2_addr  (id_rs2_addr),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd_addr   (ex_rd_addr),
        .ex_mem_read  (ex_mem_read),
        .branch_taken (branch_taken),
        .dmem_busy    (dmem_busy),
        .halt_req     (halt_req),
        .resume_req   (resume_req),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .id_ex_we     (id_ex_we),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
        .if_id_flush  (if_id_flush),
        .id_ex_bubble (id_ex_bubble),
        .halted       (halted),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
    );

    always #5 clk = ~clk;

    logic [40:0] obs;
    assign obs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble,
                  halted, mem_timeout, stall_cycles, flush_cycles};

    int checks = 0;
    int errors = 0;

    // Model: remaining flush/drain cycles, consecutive busy count, halt/fault flags
    int          m_flush_left, m_drain_left, m_busy_len, m_stall, m_flushc;
    bit          m_halted, m_fault;
    logic [40:0] exp_vec;

    task automatic model_reset();
        m_flush_left = 0;
        m_drain_left = 0;
        m_busy_len   = 0;
        m_stall      = 0;
        m_flushc     = 0;
        m_halted     = 1'b0;
        m_fault      = 1'b0;
        exp_vec      = '0;
    endtask

    task automatic idle_inputs();
        id_rs1_addr  = '0;
        id_rs2_addr  = '0;
        ex_rd_addr   = '0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        ex_mem_read  = 1'b0;
        branch_taken = 1'b0;
        dmem_busy    = 1'b0;
        halt_req     = 1'b0;
        resume_req   = 1'b0;
    endtask

    // Called right after inputs change at the falling edge; computes the expected
    // outputs for this cycle and advances the model past the next rising edge.
    // Control order: pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble.
    task automatic eval_model();
        logic [6:0]  c;
        bit          cur_halted, cur_fault, lu;
        logic [15:0] es, ef;
        #1;
        if (!reset_n) begin
            model_reset();
            return;
        end
        cur_halted = m_halted;
        cur_fault  = m_fault;
        es = STATS_EN ? 16'(m_stall)  : 16'h0000;
        ef = STATS_EN ? 16'(m_flushc) : 16'h0000;
        lu = ex_mem_read && ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                             (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
        c = 7'b0000000;
        if (m_halted) begin
            if (resume_req && !m_fault) m_halted = 1'b0;
        end else if (dmem_busy) begin
            m_busy_len++;
            if (m_busy_len >= MEM_TIMEOUT) begin
                m_fault      = 1'b1;
                m_halted     = 1'b1;
                m_flush_left = 0;
                m_drain_left = 0;
            end
        end else begin
            m_busy_len = 0;
            if (m_flush_left > 0) begin
                c = 7'b1111111;
                if (branch_taken) m_flush_left = BR_FLUSH_CYCLES - 1;
                else              m_flush_left--;
            end else if (m_drain_left > 0) begin
                c = 7'b0011101;
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1'b1;
            end else if (branch_taken) begin
                c = 7'b1111111;
                m_flush_left = BR_FLUSH_CYCLES - 1;
            end else if (lu) begin
                c = 7'b0011101;
            end else if (halt_req) begin
                c = 7'b0111111;
                m_drain_left = DRAIN_CYCLES;
            end else begin
                c = 7'b1111100;
            end
        end
        if (!c[6] && !cur_halted && m_stall < 65535) m_stall++;
        if (c[1] && m_flushc < 65535) m_flushc++;
        exp_vec = {c, cur_halted, cur_fault, es, ef};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        eval_model();
        checks++;
        if (obs !== 41'h0) begin
            errors++;
            $display("FAIL reset_asserted got=%h exp=%h", obs, 41'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        eval_model();
        checks++;
        if (obs !== exp_vec) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", obs, exp_vec);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        // {uses1, uses2, rs1, rs2, rd}: rs1 hit, rs2 hit, r0 hit, width miss, unused hit
        logic [10:0] tbl [5] = '{{1'b1, 1'b0, 3'd3, 3'd1, 3'd3}, {1'b0, 1'b1, 3'd2, 3'd6, 3'd6},
                                 {1'b1, 1'b1, 3'd0, 3'd5, 3'd0}, {1'b1, 1'b1, 3'd7, 3'd1, 3'd3},
                                 {1'b0, 1'b0, 3'd4, 3'd4, 3'd4}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_inputs();
            ex_mem_read = 1'b1;
            {id_uses_rs1, id_uses_rs2, id_rs1_addr, id_rs2_addr, ex_rd_addr} = tbl[i];
            eval_model();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL load_use_hit%0d got=%h exp=%h", i, obs, exp_vec);
            end
            @(negedge clk);
            idle_inputs();
            eval_model();
            checks++;
            if ({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} !== 5'b11111) begin
                errors++;
                $display("FAIL load_use_after%0d got=%b exp=%b", i,
                         {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, 5'b11111);
            end
        end
        // Directed case: one-cycle stall pattern, checked as plain constants
        @(negedge clk);
        idle_inputs();
        ex_mem_read = 1'b1; ex_rd_addr = 3'd3; id_rs1_addr = 3'd3; id_uses_rs1 = 1'b1;
        eval_model();
        checks++;
        if ({pc_we, if_id_we, id_ex_we, id_ex_bubble} !== 4'b0011) begin
            errors++;
            $display("FAIL load_use_directed got=%b exp=%b",
                     {pc_we, if_id_we, id_ex_we, id_ex_bubble}, 4'b0011);
        end
        $display("test_load_use done");
    endtask

    task automatic test_branch();
        int nflush = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            branch_taken = (i == 0);
            eval_model();
            nflush += int'(if_id_flush && id_ex_bubble && pc_we);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL branch_cyc%0d got=%h exp=%h", i, obs, exp_vec);
            end
        end
        checks++;
        if (nflush != BR_FLUSH_CYCLES) begin
            errors++;
            $display("FAIL branch_flush_len got=%0d exp=%0d", nflush, BR_FLUSH_CYCLES);
        end
        $display("test_branch done");
    endtask

    task automatic test_busy_in_flush();
        int nflush = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            idle_inputs();
            branch_taken = (i == 0);
            dmem_busy    = (i >= 1 && i <= 4);
            eval_model();
            if (i >= 5) nflush += int'(if_id_flush);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL busy_flush_cyc%0d got=%h exp=%h", i, obs, exp_vec);
            end
        end
        checks++;
        if (nflush != BR_FLUSH_CYCLES - 1 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL busy_flush_remaining got=%0d/%b exp=%0d/0", nflush, mem_timeout,
                     BR_FLUSH_CYCLES - 1);
        end
        $display("test_busy_in_flush done");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < MEM_TIMEOUT + 3; i++) begin
            @(negedge clk);
            idle_inputs();
            dmem_busy  = (i < MEM_TIMEOUT);
            resume_req = (i == MEM_TIMEOUT + 1);
            eval_model();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL timeout_cyc%0d got=%h exp=%h", i, obs, exp_vec);
            end
        end
        checks++;
        if ({halted, mem_timeout} !== 2'b11) begin
            errors++;
            $display("FAIL timeout_sticky got=%b exp=11", {halted, mem_timeout});
        end
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        eval_model();
        checks++;
        if (obs !== 41'h0) begin
            errors++;
            $display("FAIL timeout_reset got=%h exp=%h", obs, 41'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        eval_model();
        checks++;
        if (obs !== exp_vec) begin
            errors++;
            $display("FAIL timeout_recover got=%h exp=%h", obs, exp_vec);
        end
        $display("test_timeout done");
    endtask

    task automatic test_halt();
        int ndrain = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle_inputs();
            halt_req   = (i <= 3);
            resume_req = (i == 6);
            eval_model();
            if (i >= 1 && i <= 5)
                ndrain += int'(ex_mem_we && mem_wb_we && !pc_we && !if_id_we);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL halt_cyc%0d got=%h exp=%h", i, obs, exp_vec);
            end
        end
        checks++;
        if (ndrain != DRAIN_CYCLES) begin
            errors++;
            $display("FAIL halt_drain_len got=%0d exp=%0d", ndrain, DRAIN_CYCLES);
        end
        $display("test_halt done");
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            idle_inputs();
            halt_req = (i == 0);
            eval_model();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL mid_drain_cyc%0d got=%h exp=%h", i, obs, exp_vec);
            end
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== 41'h0) begin
            errors++;
            $display("FAIL mid_drain_reset got=%h exp=%h", obs, 41'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        eval_model();
        checks++;
        if (obs !== exp_vec) begin
            errors++;
            $display("FAIL mid_drain_release got=%h exp=%h", obs, exp_vec);
        end
        $display("test_reset_mid_drain done");
    endtask

    task automatic test_back_to_back();
        // {branch, busy, halt, resume, load_use}: branch restart inside flush,
        // halt deferred behind load-use, busy during drain, then resume
        logic [4:0] tbl [14] = '{5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b00101,
                                 5'b00100, 5'b00000, 5'b01000, 5'b01000, 5'b00000,
                                 5'b00000, 5'b00000, 5'b00010, 5'b00000};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            idle_inputs();
            {branch_taken, dmem_busy, halt_req, resume_req, ex_mem_read} = tbl[i];
            id_uses_rs2 = ex_mem_read;
            id_rs2_addr = 3'd5;
            ex_rd_addr  = 3'd5;
            eval_model();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL back_to_back_cyc%0d got=%h exp=%h", i, obs, exp_vec);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        int burst = 0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            idle_inputs();
            reset_n = !(m_fault && $urandom_range(0, 3) == 0);
            if (burst == 0 && $urandom_range(0, 99) < 8) burst = $urandom_range(1, MEM_TIMEOUT + 2);
            dmem_busy    = (burst > 0);
            if (burst > 0) burst--;
            branch_taken = ($urandom_range(0, 99) < 15);
            halt_req     = ($urandom_range(0, 99) < 6);
            resume_req   = ($urandom_range(0, 99) < 25);
            ex_mem_read  = ($urandom_range(0, 1) == 1);
            id_uses_rs1  = ($urandom_range(0, 1) == 1);
            id_uses_rs2  = ($urandom_range(0, 1) == 1);
            id_rs1_addr  = REG_ADDR_W'($urandom_range(0, 7));
            id_rs2_addr  = REG_ADDR_W'($urandom_range(0, 7));
            ex_rd_addr   = REG_ADDR_W'($urandom_range(0, 7));
            eval_model();
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random_cyc%0d got=%h exp=%h", i, obs, exp_vec);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_busy_in_flush();
        test_timeout();
        test_halt();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
